// File: rtl/l2_cmd_sequencer.sv
// L2 front-end: arbitrates snoop/L1D/L1I, issues one lookup at a time, reports MESI/snoop result and stats.
// Latency grant->done 3 cycles minimum; holds c_req_valid until c_req_ready, one command outstanding.
module l2_cmd_sequencer #(
  parameter int AW        = 32,
  parameter int CW        = 16,
  parameter int SNOOP_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          snp_valid,
  input  logic [7:0]    snp_cmd,
  input  logic [AW-1:0] snp_addr,
  output logic          snp_ack,
  input  logic          l1d_valid,
  input  logic [7:0]    l1d_cmd,
  input  logic [AW-1:0] l1d_addr,
  output logic          l1d_ack,
  input  logic          l1i_valid,
  input  logic [AW-1:0] l1i_addr,
  output logic          l1i_ack,
  output logic          c_req_valid,
  output logic [7:0]    c_req_cmd,
  output logic [AW-1:0] c_req_addr,
  input  logic          c_req_ready,
  input  logic          c_rsp_valid,
  input  logic [1:0]    c_rsp_mesi,
  output logic          done_valid,
  output logic [1:0]    done_src,
  output logic [1:0]    done_mesi,
  output logic [1:0]    snoop_result,
  output logic          cmd_err,
  output logic [CW-1:0] acc_count,
  output logic [CW-1:0] hit_count
);

  localparam int SW = $clog2(SNOOP_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  state_t          state, state_nxt;
  logic [7:0]      cmd_q;
  logic [AW-1:0]   addr_q;
  logic [1:0]      src_q;
  logic            rr_q;      // 0 favours L1D, 1 favours L1I
  logic [SW-1:0]   streak_q;

  logic            arb_en, l1_pend, snp_win, l1_go, l1d_win, l1i_win, any_win;
  logic            sel_legal, is_print, grant_issue, rsp_done;
  logic [7:0]      sel_cmd;
  logic [AW-1:0]   sel_addr;
  logic [1:0]      sel_src;
  logic [1:0]      rsp_result;

  // The completion cycle is not an arbitration slot, so done_valid never overlaps a grant.
  always_comb begin
    arb_en   = (state == IDLE) && !done_valid;
    l1_pend  = l1d_valid || l1i_valid;
    snp_win  = arb_en && snp_valid &&
               !((streak_q == SW'(SNOOP_MAX)) && l1_pend);
    l1_go    = arb_en && !snp_win && l1_pend;
    l1d_win  = l1_go && l1d_valid && (!l1i_valid || !rr_q);
    l1i_win  = l1_go && !l1d_win;
    any_win  = snp_win || l1d_win || l1i_win;
    snp_ack  = snp_win;
    l1d_ack  = l1d_win;
    l1i_ack  = l1i_win;

    sel_cmd   = 8'd2;
    sel_addr  = l1i_addr;
    sel_src   = 2'd2;
    sel_legal = 1'b1;
    if (snp_win) begin
      sel_cmd   = snp_cmd;
      sel_addr  = snp_addr;
      sel_src   = 2'd0;
      sel_legal = snp_cmd inside {8'd3, 8'd4, 8'd5, 8'd6};
    end else if (l1d_win) begin
      sel_cmd   = l1d_cmd;
      sel_addr  = l1d_addr;
      sel_src   = 2'd1;
      sel_legal = l1d_cmd inside {8'd0, 8'd1, 8'd8, 8'd9};
    end
    is_print    = l1d_win && (l1d_cmd == 8'd9);
    grant_issue = any_win && sel_legal && !is_print;
    rsp_done    = (state == WAIT_RSP) && c_rsp_valid;

    rsp_result = 2'd0;
    if (cmd_q == 8'd4 || cmd_q == 8'd6) begin
      if (c_rsp_mesi == 2'd3)      rsp_result = 2'd2;
      else if (c_rsp_mesi != 2'd0) rsp_result = 2'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (grant_issue) state_nxt = ISSUE;
      ISSUE:    if (c_req_ready) state_nxt = WAIT_RSP;
      WAIT_RSP: if (c_rsp_valid) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign c_req_valid = (state == ISSUE);
  assign c_req_cmd   = cmd_q;
  assign c_req_addr  = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cmd_q    <= '0;
      addr_q   <= '0;
      src_q    <= '0;
      rr_q     <= 1'b0;
      streak_q <= '0;
    end else begin
      state <= state_nxt;
      if (any_win) begin
        cmd_q  <= sel_cmd;
        addr_q <= sel_addr;
        src_q  <= sel_src;
      end
      if (snp_win) begin
        if (streak_q != SW'(SNOOP_MAX)) streak_q <= streak_q + 1'b1;
      end else if (l1d_win || l1i_win) begin
        streak_q <= '0;
      end
      if (l1d_win)      rr_q <= 1'b1;
      else if (l1i_win) rr_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_valid   <= 1'b0;
      done_src     <= '0;
      done_mesi    <= '0;
      snoop_result <= '0;
      cmd_err      <= 1'b0;
      acc_count    <= '0;
      hit_count    <= '0;
    end else begin
      done_valid <= 1'b0;
      cmd_err    <= any_win && !sel_legal;
      if (is_print) begin
        done_valid   <= 1'b1;
        done_src     <= 2'd1;
        done_mesi    <= 2'd0;
        snoop_result <= 2'd0;
      end else if (rsp_done) begin
        done_valid   <= 1'b1;
        done_src     <= src_q;
        done_mesi    <= c_rsp_mesi;
        snoop_result <= rsp_result;
      end
      if (rsp_done) begin
        if (cmd_q == 8'd8) begin
          acc_count <= '0;
          hit_count <= '0;
        end else if (cmd_q inside {8'd0, 8'd1, 8'd2}) begin
          if (acc_count != {CW{1'b1}}) acc_count <= acc_count + 1'b1;
          if (c_rsp_mesi != 2'd0 && hit_count != {CW{1'b1}})
            hit_count <= hit_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_l2_cmd_sequencer.sv
// Directed bench for l2_cmd_sequencer: linear steps, inputs driven and outputs checked at the falling edge.
module tb_l2_cmd_sequencer;
  localparam int AW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          snp_valid, l1d_valid, l1i_valid;
  logic [7:0]    snp_cmd, l1d_cmd;
  logic [AW-1:0] snp_addr, l1d_addr, l1i_addr;
  logic          snp_ack, l1d_ack, l1i_ack;
  logic          c_req_valid, c_req_ready, c_rsp_valid;
  logic [7:0]    c_req_cmd;
  logic [AW-1:0] c_req_addr;
  logic [1:0]    c_rsp_mesi;
  logic          done_valid, cmd_err;
  logic [1:0]    done_src, done_mesi, snoop_result;
  logic [CW-1:0] acc_count, hit_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l2_cmd_sequencer #(.AW(AW), .CW(CW), .SNOOP_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .snp_valid(snp_valid), .snp_cmd(snp_cmd), .snp_addr(snp_addr), .snp_ack(snp_ack),
    .l1d_valid(l1d_valid), .l1d_cmd(l1d_cmd), .l1d_addr(l1d_addr), .l1d_ack(l1d_ack),
    .l1i_valid(l1i_valid), .l1i_addr(l1i_addr), .l1i_ack(l1i_ack),
    .c_req_valid(c_req_valid), .c_req_cmd(c_req_cmd), .c_req_addr(c_req_addr),
    .c_req_ready(c_req_ready), .c_rsp_valid(c_rsp_valid), .c_rsp_mesi(c_rsp_mesi),
    .done_valid(done_valid), .done_src(done_src), .done_mesi(done_mesi),
    .snoop_result(snoop_result), .cmd_err(cmd_err),
    .acc_count(acc_count), .hit_count(hit_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    snp_valid   = 1'b0; snp_cmd  = '0; snp_addr = '0;
    l1d_valid   = 1'b0; l1d_cmd  = '0; l1d_addr = '0;
    l1i_valid   = 1'b0; l1i_addr = '0;
    c_req_ready = 1'b1;
    c_rsp_valid = 1'b1;
    c_rsp_mesi  = 2'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One full transaction with ready and response both immediate; starts just after a falling edge.
  task automatic run_cmd(input int src, input logic [7:0] cmd, input logic [31:0] addr,
                         input logic [1:0] mesi, input int exp_res);
    c_rsp_mesi = mesi;
    case (src)
      0:       begin snp_valid = 1'b1; snp_cmd = cmd; snp_addr = addr; end
      1:       begin l1d_valid = 1'b1; l1d_cmd = cmd; l1d_addr = addr; end
      default: begin l1i_valid = 1'b1; l1i_addr = addr; end
    endcase
    #1;
    chk("grant_ack", 32'(src == 0 ? snp_ack : (src == 1 ? l1d_ack : l1i_ack)), 1);
    @(negedge clk);
    snp_valid = 1'b0; l1d_valid = 1'b0; l1i_valid = 1'b0;
    #1;
    chk("req_valid", 32'(c_req_valid), 1);
    chk("req_cmd", 32'(c_req_cmd), 32'(cmd));
    chk("req_addr", c_req_addr, addr);
    @(negedge clk); #1;
    chk("req_dropped", 32'(c_req_valid), 0);
    chk("early_done", 32'(done_valid), 0);
    @(negedge clk); #1;
    chk("done_valid", 32'(done_valid), 1);
    chk("done_src", 32'(done_src), 32'(src));
    chk("done_mesi", 32'(done_mesi), 32'(mesi));
    chk("snoop_result", 32'(snoop_result), 32'(exp_res));
    @(negedge clk); #1;
    chk("done_pulse", 32'(done_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] streak_pat;

    // Reset state
    do_reset();
    #1;
    chk("rst_req_valid", 32'(c_req_valid), 0);
    chk("rst_req_cmd", 32'(c_req_cmd), 0);
    chk("rst_req_addr", c_req_addr, 0);
    chk("rst_done", 32'(done_valid), 0);
    chk("rst_err", 32'(cmd_err), 0);
    chk("rst_acc", 32'(acc_count), 0);
    chk("rst_hit", 32'(hit_count), 0);

    // Statistics: three L1D reads, mesi E, I, M
    run_cmd(1, 8'd0, 32'h0000_1000, 2'd2, 0);
    run_cmd(1, 8'd0, 32'h0000_1040, 2'd0, 0);
    run_cmd(1, 8'd1, 32'h0000_1080, 2'd3, 0);
    chk("acc_after_reads", 32'(acc_count), 3);
    chk("hit_after_reads", 32'(hit_count), 2);
    run_cmd(1, 8'd8, 32'h0000_0000, 2'd1, 0);
    chk("acc_after_clear", 32'(acc_count), 0);
    chk("hit_after_clear", 32'(hit_count), 0);

    // Illegal snoop command 7
    snp_valid = 1'b1; snp_cmd = 8'd7; snp_addr = 32'hdead_0000;
    #1;
    chk("bad_snp_ack", 32'(snp_ack), 1);
    @(negedge clk);
    snp_valid = 1'b0;
    #1;
    chk("bad_snp_err", 32'(cmd_err), 1);
    chk("bad_snp_noreq", 32'(c_req_valid), 0);
    @(negedge clk); #1;
    chk("bad_snp_err_pulse", 32'(cmd_err), 0);
    chk("bad_snp_noreq2", 32'(c_req_valid), 0);
    chk("bad_snp_nodone", 32'(done_valid), 0);

    // Snoop results
    run_cmd(0, 8'd4, 32'h0000_2000, 2'd3, 2);
    run_cmd(0, 8'd4, 32'h0000_2040, 2'd1, 1);
    run_cmd(0, 8'd4, 32'h0000_2080, 2'd0, 0);
    run_cmd(0, 8'd6, 32'h0000_20c0, 2'd2, 1);
    run_cmd(0, 8'd5, 32'h0000_2100, 2'd3, 0);

    // L1D + L1I held together after reset: alternating grants, done every 4 cycles
    do_reset();
    c_rsp_mesi = 2'd2;
    l1d_valid = 1'b1; l1d_cmd = 8'd0; l1d_addr = 32'h0000_3000;
    l1i_valid = 1'b1; l1i_addr = 32'h0000_4000;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_l1d_ack", 32'(l1d_ack), 32'((k % 2) == 0));
      chk("rr_l1i_ack", 32'(l1i_ack), 32'((k % 2) == 1));
      @(negedge clk);
      if (k == 3) begin l1d_valid = 1'b0; l1i_valid = 1'b0; end
      #1;
      chk("rr_no_regrant", 32'(l1d_ack | l1i_ack), 0);
      @(negedge clk);
      @(negedge clk); #1;
      chk("rr_done", 32'(done_valid), 1);
      chk("rr_done_src", 32'(done_src), ((k % 2) == 0) ? 1 : 2);
      chk("rr_done_gap_ack", 32'(l1d_ack | l1i_ack), 0);
      @(negedge clk);
    end

    // Snoop streak with L1D pending: S S S S D S
    streak_pat = 6'b101111;
    snp_valid = 1'b1; snp_cmd = 8'd3; snp_addr = 32'h0000_5000;
    l1d_valid = 1'b1; l1d_cmd = 8'd1; l1d_addr = 32'h0000_6000;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("streak_snp_ack", 32'(snp_ack), 32'(streak_pat[k]));
      chk("streak_l1d_ack", 32'(l1d_ack), 32'(!streak_pat[k]));
      @(negedge clk);
      if (k == 4) l1d_valid = 1'b0;
      if (k == 5) snp_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
    end

    // c_req_ready low for 5 cycles
    c_req_ready = 1'b0;
    c_rsp_mesi  = 2'd1;
    l1d_valid = 1'b1; l1d_cmd = 8'd1; l1d_addr = 32'h0000_7abc;
    #1;
    chk("stall_ack", 32'(l1d_ack), 1);
    @(negedge clk);
    l1d_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) c_req_ready = 1'b1;
      #1;
      chk("stall_valid", 32'(c_req_valid), 1);
      chk("stall_cmd", 32'(c_req_cmd), 1);
      chk("stall_addr", c_req_addr, 32'h0000_7abc);
      chk("stall_nodone", 32'(done_valid), 0);
      @(negedge clk);
    end
    #1;
    chk("stall_released", 32'(c_req_valid), 0);
    @(negedge clk); #1;
    chk("stall_done", 32'(done_valid), 1);
    chk("stall_done_mesi", 32'(done_mesi), 1);
    @(negedge clk); #1;
    chk("stall_single_done", 32'(done_valid), 0);

    // Print command 9: immediate completion, no datapath access
    c_rsp_mesi = 2'd3;
    l1d_valid = 1'b1; l1d_cmd = 8'd9; l1d_addr = 32'h0000_8000;
    #1;
    chk("print_ack", 32'(l1d_ack), 1);
    @(negedge clk);
    l1d_valid = 1'b0;
    #1;
    chk("print_done", 32'(done_valid), 1);
    chk("print_mesi", 32'(done_mesi), 0);
    chk("print_result", 32'(snoop_result), 0);
    chk("print_src", 32'(done_src), 1);
    chk("print_noreq", 32'(c_req_valid), 0);
    @(negedge clk); #1;
    chk("print_pulse", 32'(done_valid), 0);
    chk("print_nocount", 32'(acc_count), 6);

    // Reset during WAIT_RSP
    c_rsp_valid = 1'b0;
    l1i_valid = 1'b1; l1i_addr = 32'h0000_9000;
    #1;
    chk("abort_ack", 32'(l1i_ack), 1);
    @(negedge clk);
    l1i_valid = 1'b0;
    #1;
    chk("abort_issue", 32'(c_req_valid), 1);
    @(negedge clk); #1;
    chk("abort_wait", 32'(c_req_valid), 0);
    rst_n = 1'b0;
    #1;
    chk("abort_acc", 32'(acc_count), 0);
    chk("abort_hit", 32'(hit_count), 0);
    chk("abort_src", 32'(done_src), 0);
    chk("abort_addr", c_req_addr, 0);
    chk("abort_done", 32'(done_valid), 0);
    c_rsp_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_no_done1", 32'(done_valid), 0);
    @(negedge clk); #1;
    chk("abort_no_done2", 32'(done_valid), 0);
    chk("abort_no_req", 32'(c_req_valid), 0);
    run_cmd(2, 8'd2, 32'h0000_a000, 2'd1, 0);
    chk("post_abort_acc", 32'(acc_count), 1);
    chk("post_abort_hit", 32'(hit_count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
